// File: rtl/vector_alu_pkg.sv
// Shared widths, opcodes and the queued op-entry layout for the vector ALU issue path.
package vector_alu_pkg;

    localparam int unsigned ALU_OP_W = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_TAG_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 5'b01010;

    // One queued vector operation: both operands, the opcode and its tag.
    typedef struct packed {
        logic [DATA_W-1:0]   r;
        logic [DATA_W-1:0]   s;
        logic [ALU_OP_W-1:0] op;
        logic [OP_TAG_W-1:0] tag;
    } op_entry_t;

endpackage

// File: rtl/vector_op_fifo.sv
// Synchronous FIFO of op entries with flush, occupancy count and head read-out.
// The caller guarantees push only when not full and pop only when not empty.
module vector_op_fifo
    import vector_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  op_entry_t              wdata_i,
    output op_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    op_entry_t           mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;

    // Storage write; no reset needed since count gates what is visible.
    always_ff @(posedge clk_i) begin
        if (push_i && !reset_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/vector_op_issue_stage.sv
// Issue/capture stage: queues vector ops, drives the head op into the combinational
// ALU unit and registers its result with a valid/ready handshake to writeback.
module vector_op_issue_stage
    import vector_alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = OP_TAG_W
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [31:0]            In_R,
    input  logic [31:0]            In_S,
    input  logic [4:0]             In_Op,
    input  logic [TAG_W-1:0]       In_Tag,
    output logic [31:0]            R,
    output logic [31:0]            S,
    output logic [4:0]             ALU_Op,
    input  logic [31:0]            Y,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [31:0]            Out_Y,
    output logic [TAG_W-1:0]       Out_Tag,
    output logic                   Out_Illegal,
    output logic [$clog2(DEPTH):0] Count
);

    // The queued entry layout is fixed by the package; reject mismatched overrides.
    if (TAG_W != OP_TAG_W) begin : g_bad_tag_w
        $error("TAG_W must equal vector_alu_pkg::OP_TAG_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    op_entry_t              wdata;
    op_entry_t              head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   cap;

    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_y_q, out_y_d;
    logic [TAG_W-1:0]       out_tag_q, out_tag_d;
    logic                   out_illegal_q, out_illegal_d;

    assign wdata = '{r: In_R, s: In_S, op: In_Op, tag: In_Tag};

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign In_Ready = !fifo_full;
    assign push     = In_Valid && In_Ready;
    // Capture whenever there is a head op and the result slot is free or draining.
    assign cap      = !fifo_empty && (!out_valid_q || Out_Ready);

    vector_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .reset_i (Reset),
        .flush_i (Flush),
        .push_i  (push),
        .pop_i   (cap),
        .wdata_i (wdata),
        .head_o  (head),
        .count_o (Count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Head operands to the ALU unit; idle inputs are zeroed when the queue is empty.
    always_comb begin
        R      = '0;
        S      = '0;
        ALU_Op = '0;
        if (!fifo_empty) begin
            R      = head.r;
            S      = head.s;
            ALU_Op = head.op;
        end
    end

    // Result register next-state: flush drops the held result, data fields hold.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_y_d       = out_y_q;
        out_tag_d     = out_tag_q;
        out_illegal_d = out_illegal_q;
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (cap) begin
            out_valid_d   = 1'b1;
            out_y_d       = Y;
            out_tag_d     = head.tag;
            out_illegal_d = (head.op != ALU_OP_ADD);
        end else if (out_valid_q && Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result register state, synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q   <= 1'b0;
            out_y_q       <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_y_q       <= out_y_d;
            out_tag_q     <= out_tag_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign Out_Valid   = out_valid_q;
    assign Out_Y       = out_y_q;
    assign Out_Tag     = out_tag_q;
    assign Out_Illegal = out_illegal_q;

endmodule

// File: tb/tb_vector_op_issue_stage.sv
// Bench for vector_op_issue_stage: directed scenarios plus random traffic, with a
// queue-based reference model and a negedge monitor acting as scoreboard.
module tb_vector_op_issue_stage;
    import vector_alu_pkg::*;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Reset;
    logic        Flush;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_R;
    logic [31:0] In_S;
    logic [4:0]  In_Op;
    logic [3:0]  In_Tag;
    logic [31:0] R;
    logic [31:0] S;
    logic [4:0]  ALU_Op;
    logic [31:0] Y;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Y;
    logic [3:0]  Out_Tag;
    logic        Out_Illegal;
    logic [2:0]  Count;

    vector_op_issue_stage #(
        .DEPTH (DEPTH),
        .TAG_W (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Flush       (Flush),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .In_R        (In_R),
        .In_S        (In_S),
        .In_Op       (In_Op),
        .In_Tag      (In_Tag),
        .R           (R),
        .S           (S),
        .ALU_Op      (ALU_Op),
        .Y           (Y),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Out_Y       (Out_Y),
        .Out_Tag     (Out_Tag),
        .Out_Illegal (Out_Illegal),
        .Count       (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model of the ALU unit: two independent 16-bit lane adds; anything else returns 0.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = a[31:16] + b[31:16];
        lo = a[15:0] + b[15:0];
        return (op == ALU_OP_ADD) ? {hi, lo} : 32'h0;
    endfunction

    always_comb Y = alu_model(R, S, ALU_Op);

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    bit   slot_v;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference model: every accepted op is owed one result, in order. The output slot
    // is occupied whenever something older than this cycle's arrival is still owed.
    initial begin
        exp_t e;
        int   exp_cnt;
        bit   next_slot;
        slot_v = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset || Flush) begin
                exp_q.delete();
                slot_v = 1'b0;
            end else begin
                exp_cnt = exp_q.size() - (slot_v ? 1 : 0);
                chk("sb_out_valid", 32'(Out_Valid), 32'(slot_v));
                chk("sb_count", 32'(Count), 32'(exp_cnt));
                chk("sb_in_ready", 32'(In_Ready), 32'(exp_cnt != DEPTH));
                if (slot_v && Out_Ready) begin
                    e = exp_q.pop_front();
                    chk("sb_out_y", Out_Y, e.y);
                    chk("sb_out_tag", 32'(Out_Tag), 32'(e.tag));
                    chk("sb_out_illegal", 32'(Out_Illegal), 32'(e.ill));
                end
                next_slot = (slot_v && !Out_Ready) || (exp_q.size() > 0);
                if (In_Valid && exp_cnt != DEPTH) begin
                    e.y   = alu_model(In_R, In_S, In_Op);
                    e.tag = In_Tag;
                    e.ill = (In_Op != ALU_OP_ADD);
                    exp_q.push_back(e);
                end
                slot_v = next_slot;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] tag, input logic [4:0] op);
        In_Valid = 1'b1;
        In_R     = $urandom;
        In_S     = $urandom;
        In_Op    = op;
        In_Tag   = tag;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Reset     = 1'b1;
        Flush     = 1'b0;
        In_Valid  = 1'b1;
        In_R      = 32'h1234_5678;
        In_S      = 32'h1111_1111;
        In_Op     = ALU_OP_ADD;
        In_Tag    = 4'h5;
        Out_Ready = 1'b1;

        // 1: reset with In_Valid held high
        repeat (3) step();
        Reset    = 1'b0;
        In_Valid = 1'b0;
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_in_ready", 32'(In_Ready), 32'd1);
        chk("rst_r", R, 32'd0);
        chk("rst_s", S, 32'd0);
        chk("rst_alu_op", 32'(ALU_Op), 32'd0);
        chk("rst_out_y", Out_Y, 32'd0);

        // 2: single add, minimum latency
        In_Valid = 1'b1;
        In_R     = 32'h0001_0002;
        In_S     = 32'h0003_0004;
        In_Op    = ALU_OP_ADD;
        In_Tag   = 4'd3;
        step();
        In_Valid = 1'b0;
        chk("lat_alu_op", 32'(ALU_Op), 32'h0A);
        chk("lat_r", R, 32'h0001_0002);
        chk("lat_s", S, 32'h0003_0004);
        chk("lat_not_yet_valid", 32'(Out_Valid), 32'd0);
        step();
        chk("add_out_valid", 32'(Out_Valid), 32'd1);
        chk("add_out_y", Out_Y, 32'h0004_0006);
        chk("add_out_tag", 32'(Out_Tag), 32'd3);
        chk("add_out_illegal", 32'(Out_Illegal), 32'd0);
        step();

        // 3: backpressure until full; sixth op must be refused
        Out_Ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_op(4'(i), ALU_OP_ADD);
            step();
        end
        In_Valid = 1'b0;
        chk("full_count", 32'(Count), 32'd4);
        chk("full_in_ready", 32'(In_Ready), 32'd0);
        chk("bp_tag0", 32'(Out_Tag), 32'd0);
        step();
        step();
        chk("bp_tag0_held", 32'(Out_Tag), 32'd0);
        chk("bp_valid_held", 32'(Out_Valid), 32'd1);
        Out_Ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("bp_drain_tag", 32'(Out_Tag), 32'(k));
            chk("bp_drain_valid", 32'(Out_Valid), 32'd1);
        end
        step();
        chk("bp_drained", 32'(Out_Valid), 32'd0);

        // 4: illegal op captured and flagged, next add clears the flag
        drive_op(4'd7, 5'b00011);
        step();
        drive_op(4'd8, ALU_OP_ADD);
        In_R = 32'hFFFF_0001;
        In_S = 32'h0002_FFFF;
        step();
        In_Valid = 1'b0;
        chk("ill_out_y", Out_Y, 32'd0);
        chk("ill_flag", 32'(Out_Illegal), 32'd1);
        chk("ill_tag", 32'(Out_Tag), 32'd7);
        step();
        chk("ill_cleared", 32'(Out_Illegal), 32'd0);
        chk("ill_next_tag", 32'(Out_Tag), 32'd8);
        chk("ill_next_y", Out_Y, 32'h0001_0000);
        step();

        // 5: steady push+pop at Count=2 across pointer wrap
        Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(4'(i), ALU_OP_ADD);
            step();
        end
        chk("pp_count_start", 32'(Count), 32'd2);
        Out_Ready = 1'b1;
        for (int i = 3; i < 10; i++) begin
            drive_op(4'(i), ALU_OP_ADD);
            step();
            chk("pp_count", 32'(Count), 32'd2);
        end
        In_Valid = 1'b0;
        repeat (6) step();

        // 6: flush with queued ops, a held result and an incoming op
        Out_Ready = 1'b0;
        for (int i = 10; i < 14; i++) begin
            drive_op(4'(i), ALU_OP_ADD);
            step();
        end
        chk("fl_pre_count", 32'(Count), 32'd3);
        chk("fl_pre_valid", 32'(Out_Valid), 32'd1);
        Flush = 1'b1;
        drive_op(4'd14, ALU_OP_ADD);
        step();
        Flush    = 1'b0;
        In_Valid = 1'b0;
        chk("fl_count", 32'(Count), 32'd0);
        chk("fl_valid", 32'(Out_Valid), 32'd0);
        chk("fl_in_ready", 32'(In_Ready), 32'd1);
        chk("fl_tag_held", 32'(Out_Tag), 32'd10);
        Out_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_output", 32'(Out_Valid), 32'd0);
        end

        // Random traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            In_Valid  = ($urandom_range(0, 3) != 0);
            In_R      = $urandom;
            In_S      = $urandom;
            In_Op     = ($urandom_range(0, 1) == 1) ? ALU_OP_ADD : 5'($urandom);
            In_Tag    = 4'($urandom);
            Out_Ready = ($urandom_range(0, 3) != 0);
            Flush     = ($urandom_range(0, 49) == 0);
            step();
        end

        // Drain everything still owed
        In_Valid  = 1'b0;
        Flush     = 1'b0;
        Out_Ready = 1'b1;
        repeat (DEPTH + 4) step();
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'(Out_Valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_op_issue_stage.md
Name: vector_op_issue_stage

Overview:
Issue and capture stage wrapped around the combinational 16-bit-lane vector ALU unit.
- Buffers incoming vector operations in a small FIFO.
- Drives the head operation onto the unit's R/S/ALU_Op inputs and registers the unit's Y output into a result register.
- Uses valid/ready handshakes on both sides.
- Sits between decode/register-read and writeback in the vector datapath.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- TAG_W, 4, width of the operation tag carried alongside each op.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Flush  in  1  synchronous; discards all queued ops and any held result.
- In_Valid  in  1  upstream op valid.
- In_Ready  out  1  stage can accept an op.
- In_R  in  32  operand R.
- In_S  in  32  operand S.
- In_Op  in  5  ALU opcode.
- In_Tag  in  TAG_W  op tag.
- R  out  32  to ALU unit, operand R of head entry.
- S  out  32  to ALU unit, operand S of head entry.
- ALU_Op  out  5  to ALU unit, opcode of head entry.
- Y  in  32  from ALU unit, combinational result.
- Out_Valid  out  1  result register holds a result.
- Out_Ready  in  1  downstream accepts the result.
- Out_Y  out  32  registered result.
- Out_Tag  out  TAG_W  tag of the registered result.
- Out_Illegal  out  1  registered op was not ALU_OP_ADD (5'b01010).
- Count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high; it has highest priority.
- Reset values: Count=0, read/write pointers=0, Out_Valid=0, Out_Y=0, Out_Tag=0, Out_Illegal=0.
- In_Ready = (Count != DEPTH). It is a combinational function of registered state only and does not depend on a same-cycle pop.
- Push: In_Valid && In_Ready at a rising edge writes {In_R, In_S, In_Op, In_Tag} at the write pointer. The write pointer increments and wraps modulo DEPTH.
- Head drive:
  - FIFO non-empty: R/S/ALU_Op are taken directly from the head entry's storage.
  - FIFO empty: R=0, S=0, ALU_Op=0.
- Capture condition: cap = (Count != 0) && (!Out_Valid || Out_Ready).
- On cap:
  - Out_Y <= Y, Out_Tag <= head tag, Out_Illegal <= (head op != ALU_OP_ADD), Out_Valid <= 1.
  - Pop the head; the read pointer wraps modulo DEPTH.
- Drain without refill: Out_Valid && Out_Ready && (Count == 0) -> Out_Valid <= 0. Out_Y, Out_Tag and Out_Illegal hold their values.
- Backpressure: Out_Valid && !Out_Ready -> the result register holds and no pop occurs. The FIFO keeps accepting until it is full.
- Count update: Count += push - pop. Push and pop in the same cycle leave Count unchanged.
- No bypass: an op pushed into an empty FIFO is driven to the unit on the next cycle.
- Minimum latency: accept at edge N -> ALU inputs valid during cycle N+1 -> Out_Valid=1 after edge N+1.
- Throughput: 1 op/cycle with Out_Ready held high.
- Flush (below Reset, above push/pop):
  - Pointers and Count go to 0 and Out_Valid goes to 0.
  - In_Valid in the same cycle is dropped.
  - Out_Y, Out_Tag and Out_Illegal keep their values.
- Illegal ops are not blocked. The unit returns Y=0 for them; that value is captured and flagged via Out_Illegal.
- Ordering: results leave strictly in acceptance order.
- Reset mid-operation: all queued ops and any held result are lost. Outputs return to their reset values after that edge.

Decomposition:
- Package vector_alu_pkg holds:
  - ALU_OP_W=5, DATA_W=32, ALU_OP_ADD=5'b01010.
  - A packed op-entry typedef {r, s, op, tag}.
- One sub-module, vector_op_fifo: a generic synchronous FIFO of op entries with push, pop, flush, count and head read-out.
- Capture and result-register logic stay in vector_op_issue_stage.

Test Plan:
1. Reset with In_Valid=1 -> after Reset release: Count=0, Out_Valid=0, In_Ready=1, R=S=0, ALU_Op=0.
2. Single add, Out_Ready=1: push R=0x00010002, S=0x00030004, Op=01010, Tag=3 at edge 0 -> ALU_Op=01010 during cycle 1. After edge 1: Out_Valid=1, Out_Y=0x00040006, Out_Tag=3, Out_Illegal=0.
3. Backpressure/full, Out_Ready=0: push 6 ops (tags 0..5).
   - First op is captured; next four fill the FIFO, so Count=4 and In_Ready=0.
   - Out_Tag=0 held stable.
   - Raise Out_Ready -> tags 1,2,3,4 emerge on consecutive cycles; the 6th op was never accepted.
4. Illegal op: push Op=5'b00011, Tag=7, with the unit returning Y=0 -> Out_Y=0, Out_Illegal=1, Out_Tag=7. The next ADD clears Out_Illegal.
5. Simultaneous push/pop at Count=2 with Out_Ready=1 and In_Valid=1 -> Count stays 2 and pointers wrap correctly across 10 consecutive ops (tags 0..9 in order).
6. Flush with Count=3, Out_Valid=1 and In_Valid=1 -> next cycle Count=0, Out_Valid=0, In_Ready=1. The op presented during the flush cycle never appears at the output.
